fifo_ptr_status: RTL and testbench
==================================

Name: fifo_ptr_status

Overview:
- Receiving end of the gray-coded pointer crossing in the dual-clock FIFO.
- Lives in one clock domain and takes that domain's local gray pointer plus the opposite domain's gray pointer, which arrives asynchronously.
- Synchronizes the remote pointer, decodes both pointers to binary, and produces the full or empty flag that drives the pointer block's `state` input, a fill level, an almost flag, and overflow/underflow error tracking.
- One instance sits in the write domain (full) and one in the read domain (empty).

Parameters:
- addrsize, 8, FIFO address width; depth = 2**addrsize, pointers are addrsize+1 bits.
- side, 0, 0 = write side (state = full), 1 = read side (state = empty).
- sync_stages, 2, flop stages on the remote pointer; legal range 2..4.
- almost_thresh, 2, distance from the boundary at which `almost` asserts.

Ports:
- clk  input  1  local domain clock.
- rst_n  input  1  asynchronous active-low reset.
- ptr_local  input  addrsize+1  local gray pointer, registered in clk domain.
- ptr_remote  input  addrsize+1  remote gray pointer, asynchronous to clk.
- c  input  1  local push (side 0) or pop (side 1) request.
- err_clr  input  1  synchronous clear of err and err_cnt.
- state  output  1  full (side 0) or empty (side 1).
- almost  output  1  almost-full or almost-empty.
- level  output  addrsize+1  occupancy as seen from this side.
- err  output  1  sticky: c was asserted while state=1.
- err_cnt  output  8  count of rejected requests, saturating at 255.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - Sync chain, err and err_cnt clear to 0.
  - With ptr_local=0, outputs read: side 0 state=0, level=0, almost=0; side 1 state=1, level=0, almost=1.
- Synchronizer:
  - ptr_remote passes through sync_stages flops; ptr_sync is the last stage.
  - Gray-to-binary conversion is done only after the final stage, never on the async input.
- Decode:
  - bin[addrsize] = gray[addrsize].
  - bin[i] = bin[i+1] ^ gray[i], for local and sync pointers.
- side 0:
  - full = (ptr_local == {~ptr_sync[addrsize:addrsize-1], ptr_sync[addrsize-2:0]}).
  - level = bin_local - bin_sync, modulo 2**(addrsize+1).
  - almost = (level >= 2**addrsize - almost_thresh).
- side 1:
  - empty = (ptr_local == ptr_sync).
  - level = bin_sync - bin_local, modulo 2**(addrsize+1).
  - almost = (level <= almost_thresh).
- Timing of state/level/almost:
  - Combinational from ptr_local and ptr_sync, both of which are flop outputs, so there is no added cycle.
  - A local pointer step is reflected in the same cycle it appears on ptr_local.
  - A remote pointer step is reflected after sync_stages clk edges.
- Conservatism:
  - Sync lag may only overstate full/empty, never understate.
  - level is pessimistic on the side that limits transfers.
- Error tracking:
  - On an edge with c=1 and state=1, err is set to 1 and err_cnt increments (saturating at 255).
  - err_clr=1 has priority over a simultaneous error event; it clears both err and err_cnt to 0 that edge.
- Wrap-around: the MSB differs between pointers after one full lap; level stays correct through the 2**(addrsize+1) pointer rollover.
- Reset mid-operation: the sync chain returns to 0 immediately, so outputs re-evaluate against remote=0 while rst_n is low.
- The two domains must be reset together.

Decomposition:
- Shared package holds:
  - side encodings SIDE_WR=0 and SIDE_RD=1;
  - err_cnt width (8) and saturation value (255);
  - gray2bin and bin2gray functions, shared with the pointer block.
- One natural sub-module: ptr_sync_chain (parameterized width and stages, async reset), reusable for the opposite direction.

Test Plan (addrsize=3, depth 8, sync_stages=2, almost_thresh=2):
- Reset, side 1, both pointers 0: state=1, almost=1, level=0, err=0, err_cnt=0.
- Side 0: step ptr_local through gray of 1..8 with remote held at 0 → level reads 1..8; almost rises at level 6; state=1 exactly at gray(8)=4'b1100.
- Side 1: local=0, remote steps to gray(3) → level=3 and state=0 exactly 2 clk edges later, not earlier.
- Wrap: local=gray(14), remote=gray(6) on side 0 → level=8, full=1; advance remote to gray(7) → level=7, full=0 after 2 edges.
- Error: side 0 full, c=1 for 3 cycles → err=1, err_cnt=3; err_clr and c high together → err=0, err_cnt=0 next edge; 300 violations → err_cnt=255.
- Reset asserted mid-transfer with remote=gray(5) → state/level re-evaluate against remote=0 while rst_n is low.

Source files
------------

// File: rtl/fifo_ptr_status_pkg.sv
// rtl/fifo_ptr_status_pkg.sv - shared encodings and gray/binary helpers for the FIFO pointer crossing
package fifo_ptr_status_pkg;

    localparam int SIDE_WR = 0;
    localparam int SIDE_RD = 1;

    localparam int              ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

    // Helpers work on a wide vector; narrower pointers are zero-extended,
    // which leaves the decode of the low bits unchanged.
    localparam int GRAY_W = 32;

    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] gray);
        logic [GRAY_W-1:0] bin;
        bin[GRAY_W-1] = gray[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/ptr_sync_chain.sv
// rtl/ptr_sync_chain.sv - multi-flop synchronizer for a gray-coded pointer bus
module ptr_sync_chain #(
    parameter int width  = 9,
    parameter int stages = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] stage_q [stages];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < stages; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < stages; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[stages-1];

endmodule

// File: rtl/fifo_ptr_status.sv
// rtl/fifo_ptr_status.sv - synchronizes the remote gray pointer and derives full/empty, level, almost and error tracking
module fifo_ptr_status
    import fifo_ptr_status_pkg::*;
#(
    parameter int addrsize      = 8,
    parameter int side          = SIDE_WR,
    parameter int sync_stages   = 2,
    parameter int almost_thresh = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [addrsize:0]    ptr_local,
    input  logic [addrsize:0]    ptr_remote,
    input  logic                 c,
    input  logic                 err_clr,
    output logic                 state,
    output logic                 almost,
    output logic [addrsize:0]    level,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int PW = addrsize + 1;
    localparam logic [addrsize:0] FULL_MASK        = PW'(3) << (addrsize - 1);
    localparam logic [addrsize:0] ALMOST_FULL_LVL  = PW'((2 ** addrsize) - almost_thresh);
    localparam logic [addrsize:0] ALMOST_EMPTY_LVL = PW'(almost_thresh);

    logic [addrsize:0] ptr_sync;
    logic [addrsize:0] bin_local;
    logic [addrsize:0] bin_sync;

    ptr_sync_chain #(
        .width  (PW),
        .stages (sync_stages)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ptr_remote),
        .q     (ptr_sync)
    );

    // Decode only the synchronized copy; the raw remote bus may be mid-transition.
    assign bin_local = PW'(gray2bin(GRAY_W'(ptr_local)));
    assign bin_sync  = PW'(gray2bin(GRAY_W'(ptr_sync)));

    generate
        if (side == SIDE_WR) begin : g_wr
            assign level  = bin_local - bin_sync;
            assign state  = (ptr_local == (ptr_sync ^ FULL_MASK));
            assign almost = (level >= ALMOST_FULL_LVL);
        end else begin : g_rd
            assign level  = bin_sync - bin_local;
            assign state  = (ptr_local == ptr_sync);
            assign almost = (level <= ALMOST_EMPTY_LVL);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (err_clr) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (c && state) begin
            err <= 1'b1;
            if (err_cnt != ERR_CNT_MAX) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_ptr_status.sv
// tb/tb_fifo_ptr_status.sv - randomized and directed bench for both sides of the pointer status block
module tb_fifo_ptr_status;

    localparam int AS     = 3;
    localparam int STAGES = 2;
    localparam int DEPTH  = 8;
    localparam int MODN   = 16;

    logic       clk;
    logic       rst_n;
    logic [3:0] ptr_local;
    logic [3:0] ptr_remote;
    logic       c;
    logic       err_clr;

    logic       state_w, almost_w, err_w;
    logic [3:0] level_w;
    logic [7:0] err_cnt_w;
    logic       state_r, almost_r, err_r;
    logic [3:0] level_r;
    logic [7:0] err_cnt_r;

    int checks   = 0;
    int failures = 0;

    int q[$];
    int m_err[2];
    int m_cnt[2];

    fifo_ptr_status #(.addrsize(AS), .side(0), .sync_stages(STAGES), .almost_thresh(2)) u_wr (
        .clk(clk), .rst_n(rst_n), .ptr_local(ptr_local), .ptr_remote(ptr_remote),
        .c(c), .err_clr(err_clr), .state(state_w), .almost(almost_w), .level(level_w),
        .err(err_w), .err_cnt(err_cnt_w)
    );

    fifo_ptr_status #(.addrsize(AS), .side(1), .sync_stages(STAGES), .almost_thresh(2)) u_rd (
        .clk(clk), .rst_n(rst_n), .ptr_local(ptr_local), .ptr_remote(ptr_remote),
        .c(c), .err_clr(err_clr), .state(state_r), .almost(almost_r), .level(level_r),
        .err(err_r), .err_cnt(err_cnt_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int b2g(input int n);
        return (n ^ (n >> 1)) & (MODN - 1);
    endfunction

    function automatic int g2b(input int g);
        for (int n = 0; n < MODN; n++) begin
            if (b2g(n) == g) return n;
        end
        return -1;
    endfunction

    // Occupancy seen by a side: distance between the two pointer counts.
    function automatic int exp_level(input int s);
        int bl, bs;
        bl = g2b(int'(ptr_local));
        bs = g2b(q[$]);
        return (s == 0) ? ((bl - bs) % MODN + MODN) % MODN : ((bs - bl) % MODN + MODN) % MODN;
    endfunction

    function automatic int exp_state(input int s);
        return (s == 0) ? int'(exp_level(0) == DEPTH) : int'(exp_level(1) == 0);
    endfunction

    function automatic int exp_almost(input int s);
        return (s == 0) ? int'(exp_level(0) >= DEPTH - 2) : int'(exp_level(1) <= 2);
    endfunction

    task automatic model_reset();
        q = {};
        for (int i = 0; i < STAGES; i++) q.push_back(0);
        m_err[0] = 0; m_err[1] = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_state_wr"},  int'(state_w),   exp_state(0));
        chk({tag, "_almost_wr"}, int'(almost_w),  exp_almost(0));
        chk({tag, "_level_wr"},  int'(level_w),   exp_level(0));
        chk({tag, "_err_wr"},    int'(err_w),     m_err[0]);
        chk({tag, "_cnt_wr"},    int'(err_cnt_w), m_cnt[0]);
        chk({tag, "_state_rd"},  int'(state_r),   exp_state(1));
        chk({tag, "_almost_rd"}, int'(almost_r),  exp_almost(1));
        chk({tag, "_level_rd"},  int'(level_r),   exp_level(1));
        chk({tag, "_err_rd"},    int'(err_r),     m_err[1]);
        chk({tag, "_cnt_rd"},    int'(err_cnt_r), m_cnt[1]);
    endtask

    task automatic step(input int cv, input int clrv);
        int st[2];
        c       = cv[0];
        err_clr = clrv[0];
        #1;
        check_all("pre");
        st[0] = exp_state(0);
        st[1] = exp_state(1);
        @(posedge clk);
        for (int s = 0; s < 2; s++) begin
            if (clrv != 0) begin
                m_err[s] = 0;
                m_cnt[s] = 0;
            end else if (cv != 0 && st[s] != 0) begin
                m_err[s] = 1;
                if (m_cnt[s] < 255) m_cnt[s]++;
            end
        end
        q.push_front(int'(ptr_remote));
        void'(q.pop_back());
        #1;
        check_all("post");
    endtask

    initial begin
        rst_n      = 1'b0;
        ptr_local  = '0;
        ptr_remote = '0;
        c          = 1'b0;
        err_clr    = 1'b0;
        model_reset();
        #3;
        check_all("rst");
        chk("rst_rd_state",  int'(state_r),   1);
        chk("rst_rd_almost", int'(almost_r),  1);
        chk("rst_rd_level",  int'(level_r),   0);
        chk("rst_rd_cnt",    int'(err_cnt_r), 0);
        chk("rst_wr_state",  int'(state_w),   0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 1; n <= 8; n++) begin
            ptr_local = 4'(b2g(n));
            step(0, 0);
            chk("walk_level", int'(level_w), n);
        end
        chk("walk_full", int'(state_w), 1);

        ptr_local  = '0;
        ptr_remote = '0;
        step(0, 0);
        step(0, 0);
        ptr_remote = 4'(b2g(3));
        step(0, 0);
        chk("lag1_empty", int'(state_r), 1);
        step(0, 0);
        chk("lag2_empty", int'(state_r), 0);
        chk("lag2_level", int'(level_r), 3);

        ptr_local  = 4'(b2g(14));
        ptr_remote = 4'(b2g(6));
        step(0, 0);
        step(0, 0);
        chk("wrap_level", int'(level_w), 8);
        chk("wrap_full",  int'(state_w), 1);
        ptr_remote = 4'(b2g(7));
        step(0, 0);
        chk("wrap_hold_full", int'(state_w), 1);
        step(0, 0);
        chk("wrap_level7", int'(level_w), 7);
        chk("wrap_nfull",  int'(state_w), 0);

        ptr_local  = 4'(b2g(8));
        ptr_remote = '0;
        step(0, 1);
        step(0, 1);
        repeat (3) step(1, 0);
        chk("err3_flag", int'(err_w), 1);
        chk("err3_cnt",  int'(err_cnt_w), 3);
        step(1, 1);
        chk("clr_flag", int'(err_w), 0);
        chk("clr_cnt",  int'(err_cnt_w), 0);
        repeat (300) step(1, 0);
        chk("sat_cnt", int'(err_cnt_w), 255);
        step(0, 1);

        ptr_local  = 4'(b2g(2));
        ptr_remote = 4'(b2g(5));
        repeat (3) step(0, 0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("midrst");
        chk("midrst_level_wr", int'(level_w), 2);
        chk("midrst_level_rd", int'(level_r), 14);
        @(posedge clk);
        #1;
        check_all("midrst_hold");
        #3;
        rst_n = 1'b1;
        step(0, 0);

        repeat (300) begin
            ptr_local  = 4'($urandom_range(0, 15));
            ptr_remote = 4'($urandom_range(0, 15));
            ptr_local  = 4'(b2g(int'(ptr_local)));
            ptr_remote = 4'(b2g(int'(ptr_remote)));
            step(int'($urandom_range(0, 1)), int'($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
